// File: rtl/program_sequencer.sv
// Writable instruction store plus sequencer for the complex-number datapath.
// Fetches a program window, issues one instruction at a time and holds each for maxclk cycles.
module program_sequencer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int TIME_W = 6,
  localparam int WORD_W = 2*DATA_W + TIME_W + 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              loop,
  input  logic              stop,
  output logic              issue_valid,
  output logic [DATA_W-1:0] operand_re,
  output logic [DATA_W-1:0] operand_im,
  output logic [3:0]        opr,
  output logic [1:0]        endwreg,
  output logic              enregA,
  output logic              enregB,
  output logic              cnstA,
  output logic              cnstB,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  // Word layout, MSB first: {operand_re, operand_im, opr, maxclk, endwreg, enregA, enregB, cnstA, cnstB}
  localparam int CNSTB_B  = 0;
  localparam int CNSTA_B  = 1;
  localparam int ENREGB_B = 2;
  localparam int ENREGA_B = 3;
  localparam int EW_LSB   = 4;
  localparam int MC_LSB   = 6;
  localparam int OP_LSB   = MC_LSB + TIME_W;
  localparam int IM_LSB   = OP_LSB + 4;
  localparam int RE_LSB   = IM_LSB + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic [WORD_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              loop_q, loop_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic [TIME_W-1:0] maxclk_q, maxclk_d;
  logic              issue_valid_q, issue_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] operand_re_q, operand_re_d;
  logic [DATA_W-1:0] operand_im_q, operand_im_d;
  logic [3:0]        opr_q, opr_d;
  logic [1:0]        endwreg_q, endwreg_d;
  logic              enreg_a_q, enreg_a_d;
  logic              enreg_b_q, enreg_b_d;
  logic              cnst_a_q, cnst_a_d;
  logic              cnst_b_q, cnst_b_d;
  logic [WORD_W-1:0] fetch_word;

  assign fetch_word = mem_q[pc_q];

  // Program store: writable only while the sequencer is idle; never reset.
  always_ff @(posedge clock) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    first_d       = first_q;
    last_d        = last_q;
    loop_d        = loop_q;
    cnt_d         = cnt_q;
    maxclk_d      = maxclk_q;
    issue_valid_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    operand_re_d  = operand_re_q;
    operand_im_d  = operand_im_q;
    opr_d         = opr_q;
    endwreg_d     = endwreg_q;
    enreg_a_d     = enreg_a_q;
    enreg_b_d     = enreg_b_q;
    cnst_a_d      = cnst_a_q;
    cnst_b_d      = cnst_b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          first_d = first_addr;
          last_d  = last_addr;
          loop_d  = loop;
          pc_d    = first_addr;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        operand_re_d  = fetch_word[RE_LSB +: DATA_W];
        operand_im_d  = fetch_word[IM_LSB +: DATA_W];
        opr_d         = fetch_word[OP_LSB +: 4];
        maxclk_d      = fetch_word[MC_LSB +: TIME_W];
        endwreg_d     = fetch_word[EW_LSB +: 2];
        enreg_a_d     = fetch_word[ENREGA_B];
        enreg_b_d     = fetch_word[ENREGB_B];
        cnst_a_d      = fetch_word[CNSTA_B];
        cnst_b_d      = fetch_word[CNSTB_B];
        issue_valid_d = 1'b1;
        state_d       = S_ISSUE;
      end
      S_ISSUE: begin
        // maxclk of zero still spends one cycle in WAIT.
        cnt_d   = (maxclk_q == '0) ? TIME_W'(1) : maxclk_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= TIME_W'(1)) begin
          if (pc_q != last_q) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else if (loop_q) begin
            pc_d    = first_q;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - TIME_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every other transition; output fields keep their values.
    if (stop && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      busy_d        = 1'b0;
      issue_valid_d = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      first_q       <= '0;
      last_q        <= '0;
      loop_q        <= 1'b0;
      cnt_q         <= '0;
      maxclk_q      <= '0;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      operand_re_q  <= '0;
      operand_im_q  <= '0;
      opr_q         <= '0;
      endwreg_q     <= '0;
      enreg_a_q     <= 1'b0;
      enreg_b_q     <= 1'b0;
      cnst_a_q      <= 1'b0;
      cnst_b_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      first_q       <= first_d;
      last_q        <= last_d;
      loop_q        <= loop_d;
      cnt_q         <= cnt_d;
      maxclk_q      <= maxclk_d;
      issue_valid_q <= issue_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      operand_re_q  <= operand_re_d;
      operand_im_q  <= operand_im_d;
      opr_q         <= opr_d;
      endwreg_q     <= endwreg_d;
      enreg_a_q     <= enreg_a_d;
      enreg_b_q     <= enreg_b_d;
      cnst_a_q      <= cnst_a_d;
      cnst_b_q      <= cnst_b_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign operand_re  = operand_re_q;
  assign operand_im  = operand_im_q;
  assign opr         = opr_q;
  assign endwreg     = endwreg_q;
  assign enregA      = enreg_a_q;
  assign enregB      = enreg_b_q;
  assign cnstA       = cnst_a_q;
  assign cnstB       = cnst_b_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: cycle numbers count from the start cycle (cycle 0).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_program_sequencer;

  localparam int WORD_W = 80;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic        start;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic        loop;
  logic        stop;
  logic        issue_valid;
  logic [31:0] operand_re;
  logic [31:0] operand_im;
  logic [3:0]  opr;
  logic [1:0]  endwreg;
  logic        enregA, enregB, cnstA, cnstB;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  program_sequencer dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .loop(loop), .stop(stop),
    .issue_valid(issue_valid), .operand_re(operand_re), .operand_im(operand_im),
    .opr(opr), .endwreg(endwreg), .enregA(enregA), .enregB(enregB),
    .cnstA(cnstA), .cnstB(cnstB), .pc(pc), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [WORD_W-1:0] mk(input logic [31:0] re, input logic [31:0] im,
                                           input logic [3:0] op, input logic [5:0] mc,
                                           input logic [1:0] ew, input logic [3:0] bits);
    return {re, im, op, mc, ew, bits};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [WORD_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Start is held during cycle 0; on return the bench sits in cycle 1.
  task automatic start_run(input logic [3:0] f, input logic [3:0] l, input logic lp);
    start = 1'b1; first_addr = f; last_addr = l; loop = lp;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    first_addr = '0; last_addr = '0; loop = 1'b0; stop = 1'b0;
    tick(); tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_iv: got %b want 0", issue_valid); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (pc !== 4'd0) $display("FAIL reset_pc: got %0d want 0", pc); else n_pass++;
    n_total++; if (operand_re !== 32'd0) $display("FAIL reset_re: got %h want 0", operand_re); else n_pass++;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_timing();
    logic exp_iv, exp_done, exp_busy;
    write_word(4'd0, mk(32'h1, 32'h2, 4'd1, 6'd1, 2'd0, 4'b0000));
    write_word(4'd1, mk(32'h3, 32'h4, 4'd2, 6'd2, 2'd1, 4'b0001));
    write_word(4'd2, mk(32'h5, 32'h6, 4'd3, 6'd38, 2'd2, 4'b0010));
    start_run(4'd0, 4'd2, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      exp_iv   = (k == 2) || (k == 5) || (k == 9);
      exp_done = (k == 48);
      exp_busy = (k <= 48);
      n_total++; if (issue_valid !== exp_iv) $display("FAIL basic_iv c%0d: got %b want %b", k, issue_valid, exp_iv); else n_pass++;
      n_total++; if (done !== exp_done) $display("FAIL basic_done c%0d: got %b want %b", k, done, exp_done); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL basic_busy c%0d: got %b want %b", k, busy, exp_busy); else n_pass++;
      if (k == 9) begin
        n_total++; if (pc !== 4'd2) $display("FAIL basic_pc: got %0d want 2", pc); else n_pass++;
        n_total++; if (opr !== 4'd3) $display("FAIL basic_opr: got %0d want 3", opr); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_fields_write_start();
    // Write and start in the same cycle: the new word must be the one fetched.
    wr_en = 1'b1; wr_addr = 4'd3;
    wr_data = mk(32'hAAAA_AAAA, 32'h5555_5555, 4'd9, 6'd2, 2'd3, 4'b1010);
    start = 1'b1; first_addr = 4'd3; last_addr = 4'd3; loop = 1'b0;
    tick();
    wr_en = 1'b0; start = 1'b0;
    tick();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL fld_iv: got %b want 1", issue_valid); else n_pass++;
    n_total++; if (operand_re !== 32'hAAAA_AAAA) $display("FAIL fld_re: got %h want aaaaaaaa", operand_re); else n_pass++;
    n_total++; if (operand_im !== 32'h5555_5555) $display("FAIL fld_im: got %h want 55555555", operand_im); else n_pass++;
    n_total++; if (opr !== 4'd9) $display("FAIL fld_opr: got %0d want 9", opr); else n_pass++;
    n_total++; if (endwreg !== 2'd3) $display("FAIL fld_endwreg: got %0d want 3", endwreg); else n_pass++;
    n_total++; if ({enregA, enregB, cnstA, cnstB} !== 4'b1010)
      $display("FAIL fld_bits: got %b want 1010", {enregA, enregB, cnstA, cnstB}); else n_pass++;
    n_total++; if (pc !== 4'd3) $display("FAIL fld_pc: got %0d want 3", pc); else n_pass++;
    tick(); tick(); tick();
    n_total++; if (done !== 1'b1) $display("FAIL fld_done: got %b want 1", done); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL fld_idle: got %b want 0", busy); else n_pass++;
    n_total++; if (opr !== 4'd9) $display("FAIL fld_hold: got %0d want 9", opr); else n_pass++;
  endtask

  task automatic test_loop_stop();
    logic [3:0] seq [4];
    seq[0] = 4'd14; seq[1] = 4'd15; seq[2] = 4'd0; seq[3] = 4'd1;
    write_word(4'd14, mk(32'he, 32'h0, 4'd1, 6'd1, 2'd0, 4'b0000));
    write_word(4'd15, mk(32'hf, 32'h0, 4'd1, 6'd1, 2'd0, 4'b0000));
    write_word(4'd0,  mk(32'h0, 32'h0, 4'd1, 6'd1, 2'd0, 4'b0000));
    write_word(4'd1,  mk(32'h1, 32'h0, 4'd1, 6'd1, 2'd0, 4'b0000));
    start_run(4'd14, 4'd1, 1'b1);
    for (int k = 1; k <= 21; k++) begin
      if (k % 3 == 2) begin
        n_total++; if (issue_valid !== 1'b1) $display("FAIL loop_iv c%0d: got %b want 1", k, issue_valid); else n_pass++;
        n_total++; if (pc !== seq[((k - 2) / 3) % 4])
          $display("FAIL loop_pc c%0d: got %0d want %0d", k, pc, seq[((k - 2) / 3) % 4]); else n_pass++;
      end else begin
        n_total++; if (issue_valid !== 1'b0) $display("FAIL loop_iv c%0d: got %b want 0", k, issue_valid); else n_pass++;
      end
      n_total++; if (done !== 1'b0) $display("FAIL loop_done c%0d: got %b want 0", k, done); else n_pass++;
      if (k < 21) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL stop_state: got %0d want 0", state_dbg); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++; if (issue_valid !== 1'b0) $display("FAIL stop_iv: got %b want 0", issue_valid); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL stop_done: got %b want 0", done); else n_pass++;
      tick();
    end
  endtask

  task automatic test_maxclk_zero();
    logic exp_iv, exp_done;
    write_word(4'd5, mk(32'h50, 32'h0, 4'd1, 6'd0, 2'd0, 4'b0000));
    write_word(4'd6, mk(32'h60, 32'h0, 4'd2, 6'd1, 2'd0, 4'b0000));
    start_run(4'd5, 4'd6, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      exp_iv   = (k == 2) || (k == 5);
      exp_done = (k == 7);
      n_total++; if (issue_valid !== exp_iv) $display("FAIL mc0_iv c%0d: got %b want %b", k, issue_valid, exp_iv); else n_pass++;
      n_total++; if (done !== exp_done) $display("FAIL mc0_done c%0d: got %b want %b", k, done, exp_done); else n_pass++;
      if (k == 5) begin
        n_total++; if (opr !== 4'd2) $display("FAIL mc0_opr: got %0d want 2", opr); else n_pass++;
      end
      if (k == 8) begin
        n_total++; if (busy !== 1'b0) $display("FAIL mc0_idle: got %b want 0", busy); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    logic exp_iv, exp_done, exp_busy;
    write_word(4'd7, mk(32'h1, 32'h0, 4'd5, 6'd3, 2'd0, 4'b0000));
    write_word(4'd8, mk(32'h8, 32'h0, 4'd6, 6'd4, 2'd0, 4'b0000));
    start_run(4'd7, 4'd8, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      exp_iv   = (k == 2) || (k == 7);
      exp_done = (k == 12);
      exp_busy = (k <= 12);
      n_total++; if (issue_valid !== exp_iv) $display("FAIL busy_iv c%0d: got %b want %b", k, issue_valid, exp_iv); else n_pass++;
      n_total++; if (done !== exp_done) $display("FAIL busy_done c%0d: got %b want %b", k, done, exp_done); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL busy_busy c%0d: got %b want %b", k, busy, exp_busy); else n_pass++;
      if (k == 7) begin
        n_total++; if (pc !== 4'd8) $display("FAIL busy_pc: got %0d want 8", pc); else n_pass++;
        n_total++; if (opr !== 4'd6) $display("FAIL busy_opr: got %0d want 6", opr); else n_pass++;
      end
      wr_en = (k == 3); start = (k == 3);
      wr_addr = 4'd7; wr_data = mk(32'hDEAD, 32'h0, 4'hC, 6'd1, 2'd0, 4'b1111);
      first_addr = 4'd8; last_addr = 4'd8; loop = 1'b0;
      tick();
    end
    wr_en = 1'b0; start = 1'b0;
    start_run(4'd7, 4'd7, 1'b0);
    tick();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL rb_iv: got %b want 1", issue_valid); else n_pass++;
    n_total++; if (opr !== 4'd5) $display("FAIL rb_opr: got %0d want 5", opr); else n_pass++;
    n_total++; if (operand_re !== 32'h1) $display("FAIL rb_re: got %h want 1", operand_re); else n_pass++;
    tick(); tick(); tick(); tick();
    n_total++; if (done !== 1'b1) $display("FAIL rb_done: got %b want 1", done); else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    write_word(4'd9, mk(32'h1234, 32'h0, 4'd4, 6'd10, 2'd1, 4'b0100));
    start_run(4'd9, 4'd9, 1'b0);
    tick();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL ar_iv0: got %b want 1", issue_valid); else n_pass++;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (pc !== 4'd0) $display("FAIL ar_pc: got %0d want 0", pc); else n_pass++;
    n_total++; if (opr !== 4'd0) $display("FAIL ar_opr: got %0d want 0", opr); else n_pass++;
    n_total++; if (operand_re !== 32'd0) $display("FAIL ar_re: got %h want 0", operand_re); else n_pass++;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL ar_state: got %0d want 0", state_dbg); else n_pass++;
    tick();
    reset = 1'b1;
    tick();
    start_run(4'd9, 4'd9, 1'b0);
    tick();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL ar_iv1: got %b want 1", issue_valid); else n_pass++;
    n_total++; if (opr !== 4'd4) $display("FAIL ar_mem: got %0d want 4", opr); else n_pass++;
    n_total++; if (pc !== 4'd9) $display("FAIL ar_pc1: got %0d want 9", pc); else n_pass++;
    for (int k = 3; k <= 14; k++) begin
      tick();
      n_total++; if (done !== (k == 13)) $display("FAIL ar_done c%0d: got %b want %b", k, done, (k == 13)); else n_pass++;
    end
    n_total++; if (busy !== 1'b0) $display("FAIL ar_idle: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_fields_write_start();
    test_loop_stop();
    test_maxclk_zero();
    test_busy_ignore();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
